// File: rtl/sobel_edge_param.sv
// rtl/sobel_edge_param.sv - streamed 3x3 Sobel edge detector with binary or magnitude output
module sobel_edge_param #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int IMG_W  = 100,
    parameter int IMG_H  = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_sof,
    input  logic [DATA_W-1:0] cfg_vth,
    input  logic              cfg_mode,
    output logic              po_flag,
    output logic [OUT_W-1:0]  po_data,
    output logic              po_sof,
    output logic              po_eof
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int GW = DATA_W + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [GW-1:0] MAG_MAX  = GW'((1 << DATA_W) - 1);

    logic [CW-1:0] col_cnt, cur_col, s0_col;
    logic [RW-1:0] row_cnt, cur_row, s0_row;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic [DATA_W-1:0] vth_q;
    logic              mode_q;

    // pi_sof overrides the running position for the pixel it accompanies
    always_comb begin
        cur_col = pi_sof ? '0 : col_cnt;
        cur_row = pi_sof ? '0 : row_cnt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s0_col   <= '0;
            s0_row   <= '0;
            vth_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            s0_valid <= pi_flag;
            if (pi_flag) begin
                s0_data <= pi_data;
                s0_col  <= cur_col;
                s0_row  <= cur_row;
                if (cur_col == '0 && cur_row == '0) begin
                    vth_q  <= cfg_vth;
                    mode_q <= cfg_mode;
                end
                if (cur_col == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
                end else begin
                    col_cnt <= cur_col + CW'(1);
                    row_cnt <= cur_row;
                end
            end
        end
    end

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0[s0_col];
    assign lb1_rd = lb1[s0_col];

    always_ff @(posedge sys_clk) begin
        if (s0_valid) begin
            lb1[s0_col] <= lb0_rd;
            lb0[s0_col] <= s0_data;
        end
    end

    // index 0 is the oldest column of the window, index 2 the newest
    logic [2:0][DATA_W-1:0] wa, wb, wc;
    logic              s1_valid, s1_sof, s1_eof, s1_mode;
    logic [DATA_W-1:0] s1_vth;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wa       <= '0;
            wb       <= '0;
            wc       <= '0;
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_vth   <= '0;
            s1_mode  <= 1'b0;
        end else begin
            s1_valid <= s0_valid && (s0_row >= ROW_TWO) && (s0_col >= COL_TWO);
            s1_sof   <= (s0_row == ROW_TWO) && (s0_col == COL_TWO);
            s1_eof   <= (s0_row == ROW_LAST) && (s0_col == COL_LAST);
            s1_vth   <= vth_q;
            s1_mode  <= mode_q;
            if (s0_valid) begin
                wa <= {lb1_rd, wa[2], wa[1]};
                wb <= {lb0_rd, wb[2], wb[1]};
                wc <= {s0_data, wc[2], wc[1]};
            end
        end
    end

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] x);
        return $signed({3'b000, x});
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, gx, gy;
    logic              s2_valid, s2_sof, s2_eof, s2_mode;
    logic [DATA_W-1:0] s2_vth;

    always_comb begin
        gx_c = (ext(wa[2]) - ext(wa[0])) + ((ext(wb[2]) - ext(wb[0])) <<< 1)
             + (ext(wc[2]) - ext(wc[0]));
        gy_c = (ext(wa[0]) - ext(wc[0])) + ((ext(wa[1]) - ext(wc[1])) <<< 1)
             + (ext(wa[2]) - ext(wc[2]));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gx       <= '0;
            gy       <= '0;
            s2_valid <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eof   <= 1'b0;
            s2_vth   <= '0;
            s2_mode  <= 1'b0;
        end else begin
            gx       <= gx_c;
            gy       <= gy_c;
            s2_valid <= s1_valid;
            s2_sof   <= s1_sof;
            s2_eof   <= s1_eof;
            s2_vth   <= s1_vth;
            s2_mode  <= s1_mode;
        end
    end

    logic [GW-1:0]     abs_x, abs_y, mag_sum;
    logic [DATA_W-1:0] mag_c, mag;
    logic              s3_valid, s3_sof, s3_eof, s3_mode;
    logic [DATA_W-1:0] s3_vth;

    // sum cannot overflow GW bits: at most 8 * (2^DATA_W - 1)
    always_comb begin
        abs_x   = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_y   = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag_sum = abs_x + abs_y;
        mag_c   = (mag_sum > MAG_MAX) ? '1 : mag_sum[DATA_W-1:0];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mag      <= '0;
            s3_valid <= 1'b0;
            s3_sof   <= 1'b0;
            s3_eof   <= 1'b0;
            s3_vth   <= '0;
            s3_mode  <= 1'b0;
        end else begin
            mag      <= mag_c;
            s3_valid <= s2_valid;
            s3_sof   <= s2_sof;
            s3_eof   <= s2_eof;
            s3_vth   <= s2_vth;
            s3_mode  <= s2_mode;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_flag <= 1'b0;
            po_data <= '0;
            po_sof  <= 1'b0;
            po_eof  <= 1'b0;
        end else begin
            po_flag <= s3_valid;
            po_sof  <= s3_valid && s3_sof;
            po_eof  <= s3_valid && s3_eof;
            if (s3_valid) begin
                if (s3_mode)
                    po_data <= OUT_W'(mag);
                else
                    po_data <= (mag > s3_vth) ? '0 : '1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_param.sv
// tb/tb_sobel_edge_param.sv - self-checking bench for sobel_edge_param
module tb_sobel_edge_param;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int NOUT = (IW - 2) * (IH - 2);

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          pi_flag;
    logic [DW-1:0] pi_data;
    logic          pi_sof;
    logic [DW-1:0] cfg_vth;
    logic          cfg_mode;
    logic          po_flag;
    logic [OW-1:0] po_data;
    logic          po_sof;
    logic          po_eof;

    sobel_edge_param #(.DATA_W(DW), .OUT_W(OW), .IMG_W(IW), .IMG_H(IH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .pi_flag(pi_flag), .pi_data(pi_data), .pi_sof(pi_sof),
        .cfg_vth(cfg_vth), .cfg_mode(cfg_mode),
        .po_flag(po_flag), .po_data(po_data), .po_sof(po_sof), .po_eof(po_eof)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int pat;
        bit mode;
        int vth;
        int thr;
        bit sof;
        int e_edge;
        int e_other;
    } vec_t;

    typedef struct {
        int data;
        bit sof;
        bit eof;
        int due;
    } exp_t;

    int   n_chk = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   img [IH][IW];
    int   m_r, m_c, m_vth;
    bit   m_mode;
    exp_t exp_q [$];
    int   got_q [$];
    int   n_sof, n_eof;
    vec_t vt [12];

    task automatic check(input string name, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic int ref_mag(input int r, input int c);
        int a [3];
        int b [3];
        int d [3];
        int gx, gy, m;
        for (int j = 0; j < 3; j++) begin
            a[j] = img[r-2][c-2+j];
            b[j] = img[r-1][c-2+j];
            d[j] = img[r][c-2+j];
        end
        gx = (a[2] - a[0]) + 2 * (b[2] - b[0]) + (d[2] - d[0]);
        gy = (a[0] - d[0]) + 2 * (a[1] - d[1]) + (a[2] - d[2]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > (1 << DW) - 1) ? (1 << DW) - 1 : m;
    endfunction

    // reference: whole-frame image array, outputs predicted per completed window
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_r = 0; m_c = 0; m_vth = 0; m_mode = 0;
            exp_q.delete();
        end else begin
            cyc = cyc + 1;
            if (pi_flag) begin
                exp_t e;
                int   m;
                if (pi_sof) begin m_r = 0; m_c = 0; end
                if (m_r == 0 && m_c == 0) begin m_vth = int'(cfg_vth); m_mode = cfg_mode; end
                img[m_r][m_c] = int'(pi_data);
                if (m_r >= 2 && m_c >= 2) begin
                    m = ref_mag(m_r, m_c);
                    e.data = m_mode ? m : (m > m_vth ? 0 : 'hFFFF);
                    e.sof = (m_r == 2 && m_c == 2);
                    e.eof = (m_r == IH - 1 && m_c == IW - 1);
                    e.due = cyc + 4;
                    exp_q.push_back(e);
                end
                if (m_c == IW - 1) begin
                    m_c = 0;
                    m_r = (m_r == IH - 1) ? 0 : m_r + 1;
                end else begin
                    m_c = m_c + 1;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (po_flag) begin
                got_q.push_back(int'(po_data));
                if (po_sof) n_sof++;
                if (po_eof) n_eof++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("po_data", po_data, e.data);
                    check("po_sof", po_sof, e.sof);
                    check("po_eof", po_eof, e.eof);
                    check("latency", cyc, e.due);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("missing_output", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic int pixval(input int pat, input int c);
        case (pat)
            0:       return 50;
            1:       return (c < 4) ? 0 : 100;
            2:       return (c < 4) ? 100 : 0;
            3:       return 3 * c;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic drive_pix(input int pat, input int c, input bit sof, input int thr);
        int gap;
        pi_flag = 1'b1;
        pi_data = DW'(pixval(pat, c));
        pi_sof  = sof;
        @(posedge sys_clk); #1;
        gap = (thr == 1) ? 2 : (thr == 2) ? int'($urandom_range(0, 2)) : 0;
        if (gap > 0) begin
            pi_flag = 1'b0;
            pi_sof  = 1'b0;
            repeat (gap) begin @(posedge sys_clk); #1; end
        end
    endtask

    task automatic idle(input int n);
        pi_flag = 1'b0;
        pi_sof  = 1'b0;
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic send_frame(input vec_t v, input bit chg);
        got_q.delete();
        n_sof = 0;
        n_eof = 0;
        cfg_mode = v.mode;
        cfg_vth  = DW'(v.vth);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                if (chg && r == 2 && c == 0) cfg_vth = DW'(v.vth + 1);
                drive_pix(v.pat, c, v.sof && r == 0 && c == 0, v.thr);
            end
        idle(8);
        check("frame_count", got_q.size(), NOUT);
        check("frame_sof_count", n_sof, 1);
        check("frame_eof_count", n_eof, 1);
        if (v.pat != 4)
            for (int i = 0; i < got_q.size(); i++)
                check("frame_value", got_q[i],
                      ((i % (IW - 2)) + 1 == 3 || (i % (IW - 2)) + 1 == 4) ? v.e_edge : v.e_other);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        sys_rst_n = 1'b0;
        pi_flag = 1'b0; pi_data = '0; pi_sof = 1'b0;
        cfg_vth = '0; cfg_mode = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_po_flag", po_flag, 0);
        check("rst_po_data", po_data, 0);
        check("rst_po_sof", po_sof, 0);
        check("rst_po_eof", po_eof, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        vt[0]  = '{0, 0, 12, 0, 1, 'hFFFF, 'hFFFF};
        vt[1]  = '{1, 1, 12, 0, 0, 'h00FF, 'h0000};
        vt[2]  = '{1, 0, 12, 0, 1, 'h0000, 'hFFFF};
        vt[3]  = '{2, 1, 12, 0, 0, 'h00FF, 'h0000};
        vt[4]  = '{3, 1, 0,  0, 0, 24, 24};
        vt[5]  = '{3, 0, 24, 0, 1, 'hFFFF, 'hFFFF};
        vt[6]  = '{3, 0, 23, 0, 0, 'h0000, 'h0000};
        vt[7]  = '{0, 0, 12, 1, 0, 'hFFFF, 'hFFFF};
        vt[8]  = '{1, 1, 12, 1, 1, 'h00FF, 'h0000};
        vt[9]  = '{2, 0, 12, 1, 0, 'h0000, 'hFFFF};
        vt[10] = '{4, 1, int'($urandom_range(0, 255)), 2, 0, 0, 0};
        vt[11] = '{4, 0, int'($urandom_range(20, 200)), 2, 1, 0, 0};
        for (int i = 0; i < 12; i++) send_frame(vt[i], 1'b0);

        // threshold raised mid-frame must not affect the current frame
        send_frame('{3, 0, 23, 0, 1, 'h0000, 'h0000}, 1'b1);
        send_frame('{3, 0, 24, 0, 0, 'hFFFF, 'hFFFF}, 1'b0);

        // abandon a frame at (3,2) and resync
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IW; c++)
                if (r < 3 || c < 2) drive_pix(0, c, r == 0 && c == 0, 0);
        idle(8);
        send_frame('{1, 1, 12, 0, 1, 'h00FF, 'h0000}, 1'b0);

        // reset in the middle of a frame with outputs in flight
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IW; c++)
                if (r < 3 || c < 6) drive_pix(4, c, r == 0 && c == 0, 0);
        pi_flag = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_po_flag", po_flag, 0);
        check("midrst_po_data", po_data, 0);
        check("midrst_po_sof", po_sof, 0);
        check("midrst_po_eof", po_eof, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        send_frame('{0, 0, 12, 0, 0, 'hFFFF, 'hFFFF}, 1'b0);
        send_frame('{2, 1, 12, 2, 0, 'h00FF, 'h0000}, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
